uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Transmit queue that sits directly upstream of the UART transmitter. Buffers bytes written by the host in a FIFO and sequences them into the UART one frame at a time. It drives the UART's `tx_data_in` and `tx_start`, then waits for the UART's `tx_done` before launching the next byte. This decouples bursty host writes from the slow serial line.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- START_HOLD, 300, number of clk cycles `tx_start` is held high per frame; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe; one byte per cycle.
- wr_data  in  8  host byte.
- flush  in  1  synchronous clear of all queued (not yet launched) bytes.
- tx_done  in  1  UART transmit-complete indication; level or pulse.
- tx_start  out  1  UART start request.
- tx_data_in  out  8  byte presented to the UART; stable from launch until the next launch.
- full  out  1  `level == DEPTH`.
- empty  out  1  `level == 0`.
- level  out  $clog2(DEPTH)+1  number of queued bytes.
- busy  out  1  high when the FSM is not in IDLE.
- ovf_count  out  8  overflow counter (see Configuration).

## Operation
- FIFO: circular buffer with `$clog2(DEPTH)`-bit read and write pointers that wrap modulo DEPTH; `level` is a separate counter.
- Write: a write is accepted when `wr_en && !full && !flush`.
  - A write while full is dropped, even if a pop occurs in the same cycle; the FIFO contents are unchanged.
  - A write and a pop in the same cycle leave `level` unchanged.
- Flush: read pointer, write pointer and `level` go to 0.
  - A write in the same cycle is dropped.
  - The frame already launched is not aborted, and the FSM continues from its current state.
  - A pop is suppressed in the flush cycle.
- FSM states and transitions:
  - IDLE: if `!empty && !flush`, pop the head into `tx_data_in`, set `tx_start=1`, load the hold counter with START_HOLD-1, go to START.
  - START: `tx_start=1`. Decrement the hold counter; when it reaches 0, clear `tx_start` and go to WAIT.
  - WAIT: `tx_start=0`. When `done_seen` is set, clear it and go to IDLE.
- Done detection: `tx_done` is registered every cycle into `done_q`. A rising edge (`tx_done && !done_q`) sets the sticky flag `done_seen`.
  - The flag is cleared on entry to START, so only an edge after launch counts.
  - An edge during START is retained, and WAIT then exits on its first cycle.
  - A `tx_done` held high across launches never counts twice.
- Reset values: `tx_start=0`, `tx_data_in=8'h00`, `full=0`, `empty=1`, `level=0`, `busy=0`, `ovf_count=0`, FSM=IDLE, `done_q=0`, `done_seen=0`.
- Reset mid-frame: `tx_start` drops immediately (asynchronously) and all queued bytes are lost.

## Timing
- Write at edge k: `level` and `empty` are updated after edge k.
- Launch from IDLE at edge k+1: `tx_start` and `tx_data_in` are valid after edge k+1. First-byte latency is 2 edges from `wr_en` sampling to `tx_start` high.
- `tx_start` is high for exactly START_HOLD cycles per frame.
- Rising edge of `tx_done` at edge m while in WAIT: IDLE after edge m+1; the next launch occurs at edge m+2 if the FIFO is non-empty.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `UART_TX_QUEUE_OVF_CNT_EN`.
- Defined: `ovf_count` increments by 1 on every dropped write (`wr_en && full && !flush`). It saturates at 8'hFF and is cleared only by reset; flush does not clear it.
- Undefined: the counter logic is not compiled, and `ovf_count` is tied to 8'h00.

## Test plan
- Single byte: write 0xB4 into the empty queue, hold `tx_done` low, pulse it 2000 cycles later → `tx_start` high for exactly 300 cycles starting 2 edges after the write, `tx_data_in`=0xB4, `busy` high until 1 edge after the `tx_done` edge, `level` 1→0.
- Burst: write 0x9A, 0x55, 0x01 on consecutive cycles → the three bytes launch in order. Each launch occurs only after a new `tx_done` rising edge, 2 edges after that edge.
- Full/overflow: DEPTH=16; block launches by keeping the first frame in WAIT, then write 18 more bytes → `full`=1 and `level`=16. With the macro defined `ovf_count`=2; with it undefined `ovf_count`=0. Later drained bytes match the first 16 accepted bytes only.
- Flush during frame: queue 5 bytes, assert `flush` during START of the first → the current `tx_start` completes its 300 cycles, `level`=0 and `empty`=1, no further launches occur after `tx_done`.
- Sticky done: hold `tx_done` high continuously, then pulse it low for one cycle during START → WAIT exits on its first cycle. A level held high without a new edge causes no relaunch.
- Async reset mid-START: assert `reset` between clock edges → `tx_start`=0 immediately, `level`=0, `busy`=0, and all outputs hold their reset values until `reset` is released.

Source files
------------

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//
// Transmit queue placed in front of a UART transmitter. Host bytes are
// buffered in a circular FIFO and handed to the UART one frame at a time:
// the head byte is presented on tx_data_in, tx_start is held high for
// START_HOLD cycles, and the next byte is only launched after a fresh rising
// edge of tx_done has been observed for the current frame.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   START_HOLD  cycles tx_start stays high per frame (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   wr_en       host write strobe (one byte per cycle)
//   wr_data     host byte
//   flush       synchronous clear of all queued, not yet launched bytes
//   tx_done     UART transmit complete (level or pulse)
//   tx_start    UART start request
//   tx_data_in  byte presented to the UART, stable between launches
//   full        level == DEPTH
//   empty       level == 0
//   level       number of queued bytes
//   busy        frame sequencer is not idle
//   ovf_count   saturating count of dropped writes
//
// Optional feature
//   UART_TX_QUEUE_OVF_CNT_EN  when defined, ovf_count counts writes dropped
//                             because the queue was full; otherwise it is
//                             tied to zero.
// -----------------------------------------------------------------------------
module uart_tx_queue #(
  parameter int DEPTH      = 16,
  parameter int START_HOLD = 300
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     tx_done,
  output logic                     tx_start,
  output logic [7:0]               tx_data_in,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [7:0]               ovf_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  // A hold of one cycle still needs a one-bit counter.
  localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(START_HOLD - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]        mem_q [DEPTH];

  state_t            state_q,     state_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [LVL_W-1:0]  level_q,     level_d;
  logic [HOLD_W-1:0] hold_q,      hold_d;
  logic              tx_start_q,  tx_start_d;
  logic [7:0]        tx_data_q,   tx_data_d;
  logic              full_q,      full_d;
  logic              empty_q,     empty_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              done_seen_q, done_seen_d;

  logic              wr_accept;
  logic              pop;
  logic              done_rise;

  // Full blocks the write even if a pop happens in the same cycle; flush
  // suppresses both writes and pops.
  assign wr_accept = wr_en && !full_q && !flush;
  assign pop       = (state_q == S_IDLE) && !empty_q && !flush;
  assign done_rise = tx_done && !done_q;

  // ---------------------------------------------------------------------------
  // Storage: plain write port, no reset so it maps onto RAM primitives. The
  // read and write addresses never collide on a pop+write cycle because a
  // write is only accepted when the queue is not full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_accept, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end

    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == '0);
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    done_d     = tx_done;
    // Any rising edge is remembered until the sequencer consumes or discards it.
    done_seen_d = done_seen_q | done_rise;

    unique case (state_q)
      S_IDLE: begin
        tx_start_d = 1'b0;
        if (pop) begin
          tx_data_d   = mem_q[rd_ptr_q];
          tx_start_d  = 1'b1;
          hold_d      = HOLD_LOAD;
          // Edges seen before the launch belong to the previous frame.
          done_seen_d = 1'b0;
          state_d     = S_START;
        end
      end

      S_START: begin
        tx_start_d = 1'b1;
        if (hold_q == '0) begin
          tx_start_d = 1'b0;
          state_d    = S_WAIT;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      S_WAIT: begin
        tx_start_d = 1'b0;
        if (done_seen_q) begin
          done_seen_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      hold_q      <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      hold_q      <= hold_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_seen_q <= done_seen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow counter (optional)
  // ---------------------------------------------------------------------------
`ifdef UART_TX_QUEUE_OVF_CNT_EN
  logic       wr_drop;
  logic [7:0] ovf_q, ovf_d;

  assign wr_drop = wr_en && full_q && !flush;

  // Saturates rather than wrapping; flush deliberately leaves it alone.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 8'h00;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_start   = tx_start_q;
  assign tx_data_in = tx_data_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Directed scenarios followed by a randomized run. A reference model keeps the
// queue as a SystemVerilog queue and tracks frames by launch time: a frame
// launched at edge L drives tx_start for START_HOLD cycles, and the next
// launch becomes possible once a tx_done rising edge after L has been seen
// and the start phase is over. All outputs are compared after every edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int H     = 300;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       busy;
  logic [7:0] ovf_count;

  uart_tx_queue #(
    .DEPTH      (DEPTH),
    .START_HOLD (H)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data_in (tx_data_in),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .busy       (busy),
    .ovf_count  (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  byte unsigned m_q[$];
  bit           m_idle;
  int           m_launch;
  bit           m_seen;
  bit           m_prev_done;
  logic [7:0]   m_data;
  int           m_ovf;
  int           n_launch = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_idle      = 1'b1;
    m_launch    = -100000;
    m_seen      = 1'b0;
    m_prev_done = 1'b0;
    m_data      = 8'h00;
    m_ovf       = 0;
  endtask

  // One rising clock edge worth of model behaviour, using the inputs that the
  // DUT samples at this edge.
  task automatic model_edge();
    bit rise;
    bit full_b;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    rise        = tx_done && !m_prev_done;
    m_prev_done = tx_done;
    full_b      = (m_q.size() == DEPTH);

    if (m_idle) begin
      if (m_q.size() > 0 && !flush) begin
        m_data   = m_q.pop_front();
        m_idle   = 1'b0;
        m_launch = cyc;
        m_seen   = 1'b0;
        n_launch++;
        $display("launch #%0d byte=0x%02h cyc=%0d", n_launch, m_data, cyc);
      end
    end else if (cyc - m_launch > H) begin
      // waiting for completion: a previously seen edge ends the frame
      if (m_seen) begin
        m_idle = 1'b1;
        m_seen = 1'b0;
      end else if (rise) begin
        m_seen = 1'b1;
      end
    end else if (rise) begin
      m_seen = 1'b1;
    end

    if (flush) begin
      m_q.delete();
    end else if (wr_en) begin
      if (!full_b) m_q.push_back(wr_data);
      else if (m_ovf < 255) m_ovf++;
    end
  endtask

  task automatic check_all();
    int exp_ovf;
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    exp_ovf = m_ovf;
`else
    exp_ovf = 0;
`endif
    check_val("tx_start",   32'(tx_start),   32'(!m_idle && (cyc - m_launch) < H));
    check_val("tx_data_in", 32'(tx_data_in), 32'(m_data));
    check_val("level",      32'(level),      32'(m_q.size()));
    check_val("full",       32'(full),       32'(m_q.size() == DEPTH));
    check_val("empty",      32'(empty),      32'(m_q.size() == 0));
    check_val("busy",       32'(busy),       32'(!m_idle));
    check_val("ovf_count",  32'(ovf_count),  32'(exp_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    tx_done = 1'b0;
    model_reset();

    // reset state
    run(3);
    rst = 1'b0;
    run(2);

    // single byte
    write_byte(8'hB4);
    run(2000);
    pulse_done();
    run(20);

    // burst of three
    write_byte(8'h9A);
    write_byte(8'h55);
    write_byte(8'h01);
    for (int i = 0; i < 3; i++) begin
      run(400);
      pulse_done();
    end
    run(20);

    // full / overflow: first frame parked in WAIT, then 18 writes
    write_byte(8'h10);
    run(310);
    for (int i = 0; i < 18; i++) write_byte(8'(8'h20 + i));
    check_val("full_flag", 32'(full), 32'd1);
    check_val("full_level", 32'(level), 32'd16);
`ifdef UART_TX_QUEUE_OVF_CNT_EN
    check_val("ovf_after_full", 32'(ovf_count), 32'd2);
`else
    check_val("ovf_after_full", 32'(ovf_count), 32'd0);
`endif
    for (int i = 0; i < 17; i++) begin
      pulse_done();
      run(305);
    end
    check_val("drained_empty", 32'(empty), 32'd1);
    pulse_done();
    run(5);

    // flush during START of the first of five
    for (int i = 0; i < 5; i++) write_byte(8'(8'h60 + i));
    run(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flush_level", 32'(level), 32'd0);
    check_val("flush_empty", 32'(empty), 32'd1);
    check_val("flush_start_kept", 32'(tx_start), 32'd1);
    run(300);
    pulse_done();
    run(50);
    check_val("flush_no_relaunch", 32'(busy), 32'd0);

    // sticky done: level high, one-cycle low during START
    tx_done = 1'b1;
    run(5);
    write_byte(8'h71);
    write_byte(8'h72);
    run(10);
    tx_done = 1'b0;
    step();
    tx_done = 1'b1;
    run(300);
    run(800);
    check_val("sticky_hold_busy", 32'(busy), 32'd1);
    check_val("sticky_second_byte", 32'(tx_data_in), 32'h72);
    tx_done = 1'b0;
    run(2);
    pulse_done();
    run(5);

    // asynchronous reset in the middle of START
    write_byte(8'h81);
    write_byte(8'h82);
    run(10);
    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("async_tx_start", 32'(tx_start), 32'd0);
    check_val("async_level", 32'(level), 32'd0);
    check_val("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_all();
    run(3);
    rst = 1'b0;
    run(5);

    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      wr_en   = ($urandom_range(0, 15) == 0);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) == 0) tx_done = ~tx_done;
      step();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
